// File: rtl/raycast_pkg.sv
// Shared constants for the ray direction generator: Q8.8 format, the
// turn-angle ROM geometry, the packed field offsets of one ROM entry, and
// the frame sequencing states.
package raycast_pkg;

   localparam int QW = 16;
   localparam logic signed [QW-1:0] Q_ONE = 16'sd256;

   localparam int NUM_ANGLES = 126;
   localparam int IDX_W      = 7;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ANGLES - 1);

   // One ROM entry: {dirX, dirY, planeX, planeY, invDet}, MSB first.
   localparam int ENTRY_W    = 80;
   localparam int DIRX_LSB   = 64;
   localparam int DIRY_LSB   = 48;
   localparam int PLANEX_LSB = 32;
   localparam int PLANEY_LSB = 16;
   localparam int INVDET_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_LATCH,
      ST_RUN,
      ST_DONE
   } ray_state_e;

endpackage

// File: rtl/q88_mul.sv
// Signed Q8.8 x Q8.8 multiply, result truncated back to Q8.8 (product bits [23:8]).
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i signed Q8.8 operands; p_o signed Q8.8 product, wrapping.
module q88_mul
   import raycast_pkg::*;
(
   input  logic signed [QW-1:0] a_i,
   input  logic signed [QW-1:0] b_i,
   output logic signed [QW-1:0] p_o
);

   logic [2*QW-1:0] prod;

   // Sign-extended operands; the low 32 bits of the product are the
   // two's-complement signed product.
   assign prod = {{QW{a_i[QW-1]}}, a_i} * {{QW{b_i[QW-1]}}, b_i};
   assign p_o  = QW'(prod >> 8);

endmodule

// File: rtl/ray_dir_gen.sv
// Ray direction generator: owns the angle index, reads the turn-angle ROM, streams rayDir per column.
// Latency: frame_start in cycle T -> angle_addr in T+1, first ray_valid in T+4, then 1 ray/cycle.
// Backpressure: ray outputs hold while ray_valid & !ray_ready; a new ray loads when the slot is free.
// Ports: clk/rst (sync, active-high); frame_start, turn_left, turn_right pulses;
//        angle_addr/angle_data ROM read port; ray_valid/ray_ready/ray_col/ray_dir_x/ray_dir_y
//        ray stream; inv_det, angle_idx, busy, frame_done status.
module ray_dir_gen
   import raycast_pkg::*;
#(
   parameter int SCREEN_W = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        frame_start,
   input  logic                        turn_left,
   input  logic                        turn_right,
   output logic [IDX_W-1:0]            angle_addr,
   input  logic [ENTRY_W-1:0]          angle_data,
   output logic                        ray_valid,
   input  logic                        ray_ready,
   output logic [$clog2(SCREEN_W)-1:0] ray_col,
   output logic [QW-1:0]               ray_dir_x,
   output logic [QW-1:0]               ray_dir_y,
   output logic [QW-1:0]               inv_det,
   output logic [IDX_W-1:0]            angle_idx,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int CW  = $clog2(SCREEN_W);
   localparam int CW1 = CW + 1;
   localparam logic signed [QW-1:0] CAM_STEP = QW'(512 / SCREEN_W);
   localparam logic [CW-1:0]        LAST_COL = CW'(SCREEN_W - 1);
   localparam logic [CW:0]          COL_END  = CW1'(SCREEN_W);
   localparam logic [CW:0]          COL_INC  = CW1'(1);

   ray_state_e state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, addr_q, addr_d;
   logic             pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic signed [QW-1:0] dirx_q, dirx_d, diry_q, diry_d;
   logic signed [QW-1:0] planex_q, planex_d, planey_q, planey_d;
   logic [QW-1:0]        invdet_q, invdet_d;
   logic signed [QW-1:0] cam_q, cam_d;
   logic [CW:0]          gen_col_q, gen_col_d;   // next column to generate
   logic                 vld_q, vld_d;
   logic [CW-1:0]        col_q, col_d;
   logic [QW-1:0]        rx_q, rx_d, ry_q, ry_d;

   logic                 from_rom, accept, slot_free, load;
   logic signed [QW-1:0] op_dirx, op_diry, op_planex, op_planey, op_cam, px, py;
   logic [CW:0]          op_col;

   // The first ray is built in LATCH straight from the ROM word so it is
   // registered by T+4; later rays use the latched fields.
   assign from_rom  = (state_q == ST_LATCH);
   assign op_dirx   = from_rom ? angle_data[DIRX_LSB +: QW]   : dirx_q;
   assign op_diry   = from_rom ? angle_data[DIRY_LSB +: QW]   : diry_q;
   assign op_planex = from_rom ? angle_data[PLANEX_LSB +: QW] : planex_q;
   assign op_planey = from_rom ? angle_data[PLANEY_LSB +: QW] : planey_q;
   assign op_cam    = from_rom ? -Q_ONE : cam_q;
   assign op_col    = from_rom ? '0 : gen_col_q;

   assign accept    = vld_q & ray_ready;
   assign slot_free = ~vld_q | ray_ready;

   q88_mul u_mul_x (.a_i(op_planex), .b_i(op_cam), .p_o(px));
   q88_mul u_mul_y (.a_i(op_planey), .b_i(op_cam), .p_o(py));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      pend_l_d  = pend_l_q | turn_left;
      pend_r_d  = pend_r_q | turn_right;
      dirx_d    = dirx_q;
      diry_d    = diry_q;
      planex_d  = planex_q;
      planey_d  = planey_q;
      invdet_d  = invdet_q;
      cam_d     = cam_q;
      gen_col_d = gen_col_q;
      vld_d     = vld_q;
      col_d     = col_q;
      rx_d      = rx_q;
      ry_d      = ry_q;
      load      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               if (pend_l_q && !pend_r_q) begin
                  idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
               end else if (pend_r_q && !pend_l_q) begin
                  idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
               end
               // Pending flags consumed; a same-cycle pulse stays for next frame.
               pend_l_d = turn_left;
               pend_r_d = turn_right;
               addr_d   = idx_d;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR:  state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_LATCH;
         ST_LATCH: begin
            dirx_d   = op_dirx;
            diry_d   = op_diry;
            planex_d = op_planex;
            planey_d = op_planey;
            invdet_d = angle_data[INVDET_LSB +: QW];
            load     = 1'b1;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            if (accept && col_q == LAST_COL) begin
               vld_d   = 1'b0;
               state_d = ST_DONE;
            end else if (slot_free && gen_col_q != COL_END) begin
               load = 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (load) begin
         vld_d     = 1'b1;
         col_d     = op_col[CW-1:0];
         rx_d      = op_dirx + px;
         ry_d      = op_diry + py;
         cam_d     = op_cam + CAM_STEP;
         gen_col_d = op_col + COL_INC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         pend_l_q  <= 1'b0;
         pend_r_q  <= 1'b0;
         dirx_q    <= '0;
         diry_q    <= '0;
         planex_q  <= '0;
         planey_q  <= '0;
         invdet_q  <= '0;
         cam_q     <= '0;
         gen_col_q <= '0;
         vld_q     <= 1'b0;
         col_q     <= '0;
         rx_q      <= '0;
         ry_q      <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         pend_l_q  <= pend_l_d;
         pend_r_q  <= pend_r_d;
         dirx_q    <= dirx_d;
         diry_q    <= diry_d;
         planex_q  <= planex_d;
         planey_q  <= planey_d;
         invdet_q  <= invdet_d;
         cam_q     <= cam_d;
         gen_col_q <= gen_col_d;
         vld_q     <= vld_d;
         col_q     <= col_d;
         rx_q      <= rx_d;
         ry_q      <= ry_d;
      end
   end

   assign angle_addr = addr_q;
   assign ray_valid  = vld_q;
   assign ray_col    = col_q;
   assign ray_dir_x  = rx_q;
   assign ray_dir_y  = ry_q;
   assign inv_det    = invdet_q;
   assign angle_idx  = idx_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_DONE);

   // The index wrap logic must never leave the populated ROM range.
   idx_range_a: assert property (@(posedge clk) disable iff (rst) idx_q <= IDX_LAST);

endmodule

// File: tb/tb_ray_dir_gen.sv
module tb_ray_dir_gen;

   localparam int SCREEN_W = 256;
   localparam int CW       = $clog2(SCREEN_W);
   localparam int NA       = 126;
   localparam int STEP     = 512 / SCREEN_W;

   logic          clk = 1'b0;
   logic          rst, frame_start, turn_left, turn_right;
   logic [6:0]    angle_addr;
   logic [79:0]   angle_data;
   logic          ray_valid, ray_ready;
   logic [CW-1:0] ray_col;
   logic [15:0]   ray_dir_x, ray_dir_y, inv_det;
   logic [6:0]    angle_idx;
   logic          busy, frame_done;

   logic [79:0]   rom [128];

   int n_checks = 0;
   int n_errors = 0;
   int m_idx;
   bit m_pl, m_pr;

   ray_dir_gen #(.SCREEN_W(SCREEN_W)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .turn_left(turn_left), .turn_right(turn_right),
      .angle_addr(angle_addr), .angle_data(angle_data),
      .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_col(ray_col),
      .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .inv_det(inv_det),
      .angle_idx(angle_idx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data appears the cycle after the address.
   always_ff @(posedge clk) angle_data <= rom[angle_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // rayDir component = dir + floor(plane * cameraX / 256), cameraX = -1.0 + col*2/W
   function automatic logic [15:0] ray_comp(input logic [15:0] d, input logic [15:0] p, input int col);
      int cam, prod, sum;
      cam  = -256 + col * STEP;
      prod = int'($signed(p)) * cam;
      sum  = int'($signed(d)) + (prod >>> 8);
      return sum[15:0];
   endfunction

   function automatic void apply_turns();
      if (m_pl && !m_pr)      m_idx = (m_idx + 1) % NA;
      else if (m_pr && !m_pl) m_idx = (m_idx + NA - 1) % NA;
   endfunction

   task automatic reset_abort();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(ray_valid), 0);
      chk("rst_col",   32'(ray_col), 0);
      chk("rst_x",     32'(ray_dir_x), 0);
      chk("rst_y",     32'(ray_dir_y), 0);
      chk("rst_invdet",32'(inv_det), 0);
      chk("rst_addr",  32'(angle_addr), 0);
      chk("rst_idx",   32'(angle_idx), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(frame_done), 0);
      rst = 1'b0;
      m_idx = 0; m_pl = 0; m_pr = 0;
      ray_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(frame_done), 0);
         chk("abort_idle",    32'(busy), 0);
      end
   endtask

   // with_start: 0 none, 1 turn_left, 2 turn_right in the frame_start cycle.
   // stall_col/mid_col/rst_col: -1 disables that event.
   task automatic do_frame(input bit pre_l, input bit pre_r, input int with_start, input int ready_pct,
                           input int stall_col, input int mid_col, input int rst_col);
      logic [79:0]   e;
      logic [15:0]   ex, ey, hx, hy, dy;
      logic [CW-1:0] hcol;
      int            exp_col, cyc, stall_left;
      bit            held, mid_done;

      // Each turn pulsed twice while idle; repeated pulses still mean one step.
      if (pre_l || pre_r) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            turn_left = pre_l; turn_right = pre_r;
            if (pre_l) m_pl = 1;
            if (pre_r) m_pr = 1;
            @(negedge clk);
            turn_left = 0; turn_right = 0;
         end
      end

      @(negedge clk);
      frame_start = 1'b1;
      turn_left   = (with_start == 1);
      turn_right  = (with_start == 2);
      apply_turns();
      m_pl = (with_start == 1);
      m_pr = (with_start == 2);

      @(negedge clk);   // T+1
      frame_start = 0; turn_left = 0; turn_right = 0;
      chk("addr_t1",  32'(angle_addr), 32'(m_idx));
      chk("idx_t1",   32'(angle_idx), 32'(m_idx));
      chk("busy_t1",  32'(busy), 1);
      chk("valid_t1", 32'(ray_valid), 0);
      @(negedge clk);   // T+2
      chk("valid_t2", 32'(ray_valid), 0);
      @(negedge clk);   // T+3
      chk("valid_t3", 32'(ray_valid), 0);
      @(negedge clk);   // T+4

      e = rom[m_idx];
      chk("inv_det", 32'(inv_det), 32'(e[15:0]));
      exp_col = 0; cyc = 0; stall_left = 5; held = 0; mid_done = 0;
      hx = '0; hy = '0; hcol = '0;

      while (exp_col < SCREEN_W) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         frame_start = 0; turn_left = 0;
         if (cyc > 4000) begin
            chk("timeout_cols", 32'(exp_col), 32'(SCREEN_W));
            return;
         end
         if (rst_col == exp_col) begin
            reset_abort();
            return;
         end
         if (stall_col == exp_col && stall_left > 0) begin
            ray_ready = 1'b0;
            stall_left--;
         end else begin
            ray_ready = ($urandom_range(0, 99) < ready_pct);
         end
         if (mid_col == exp_col && !mid_done) begin
            frame_start = 1'b1; turn_left = 1'b1;
            m_pl = 1; mid_done = 1;
         end

         chk("valid_run",  32'(ray_valid), 1);
         chk("done_early", 32'(frame_done), 0);
         ex = ray_comp(e[79:64], e[47:32], exp_col);
         ey = ray_comp(e[63:48], e[31:16], exp_col);
         chk("col",   32'(ray_col), 32'(exp_col));
         chk("dir_x", 32'(ray_dir_x), 32'(ex));
         chk("dir_y", 32'(ray_dir_y), 32'(ey));
         if (held) begin
            chk("hold_col", 32'(ray_col), 32'(hcol));
            chk("hold_x",   32'(ray_dir_x), 32'(hx));
            chk("hold_y",   32'(ray_dir_y), 32'(hy));
         end
         if (m_idx == 0 && (exp_col == 0 || exp_col == 128 || exp_col == 255)) begin
            dy = (exp_col == 0) ? 16'hFF58 : (exp_col == 128) ? 16'h0000 : 16'h00A6;
            chk("entry0_x", 32'(ray_dir_x), 32'h0100);
            chk("entry0_y", 32'(ray_dir_y), 32'(dy));
         end
         held = ray_valid && !ray_ready;
         hcol = ray_col; hx = ray_dir_x; hy = ray_dir_y;
         if (ray_valid && ray_ready) exp_col++;
      end

      @(negedge clk);
      ray_ready = 1'b1; frame_start = 0; turn_left = 0;
      chk("valid_after_last", 32'(ray_valid), 0);
      chk("frame_done",       32'(frame_done), 1);
      @(negedge clk);
      chk("done_one_cycle", 32'(frame_done), 0);
      chk("idle_after",     32'(busy), 0);
   endtask

   initial begin
      logic [95:0] r96;
      for (int i = 0; i < 128; i++) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         rom[i] = r96[79:0];
      end
      rom[0] = {16'h0100, 16'h0000, 16'h0000, 16'h00A8, 16'h1234};

      rst = 1'b1; frame_start = 0; turn_left = 0; turn_right = 0; ray_ready = 1'b1;
      m_idx = 0; m_pl = 0; m_pr = 0;
      repeat (3) @(negedge clk);
      chk("reset_valid", 32'(ray_valid), 0);
      chk("reset_addr",  32'(angle_addr), 0);
      chk("reset_idx",   32'(angle_idx), 0);
      chk("reset_busy",  32'(busy), 0);
      chk("reset_done",  32'(frame_done), 0);
      chk("reset_x",     32'(ray_dir_x), 0);
      rst = 1'b0;

      do_frame(0, 0, 0, 100, -1, -1, -1);   // baseline, entry 0
      do_frame(0, 1, 0, 100, -1, -1, -1);   // 0 -> 125
      do_frame(1, 0, 0,  70, -1, -1, -1);   // 125 -> 0
      do_frame(1, 1, 0, 100, -1, -1, -1);   // both pending: unchanged
      do_frame(0, 0, 0, 100, 10, -1, -1);   // 5-cycle stall at column 10
      do_frame(0, 0, 1, 100, -1, -1, -1);   // turn in start cycle -> next frame
      do_frame(0, 0, 0, 100, -1, 50, -1);   // ignored restart + mid-frame turn
      do_frame(0, 0, 0, 100, -1, -1, -1);
      for (int f = 0; f < 4; f++) begin
         do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), int'($urandom_range(40, 100)), -1, -1, -1);
      end
      do_frame(0, 0, 0, 100, -1, 50, 100);  // reset aborts at column 100
      do_frame(0, 0, 0, 100, -1, -1, -1);   // index back at 0, pending cleared

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
